execute_cycle: RTL and testbench

EXECUTE_CYCLE -- requirements
Module: execute_cycle

---
 rtl/execute_cycle_pkg.sv | 29 ++
 rtl/execute_cycle_if.sv | 53 +++++
 rtl/execute_cycle_mul_iter.sv | 66 ++++++
 rtl/execute_cycle.sv | 128 ++++++++++++
 tb/tb_execute_cycle.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/execute_cycle_pkg.sv
// Shared definitions for the execute stage: ALU op codes, forward selects,
// multiplier FSM states and iteration count.
package execute_cycle_pkg;

    localparam int DATA_W    = 32;
    localparam int REG_W     = 5;
    localparam int MUL_STEPS = 32;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'b00,
        MUL_BUSY = 2'b01,
        MUL_DONE = 2'b10
    } mul_state_e;

endpackage

// File: rtl/execute_cycle_if.sv
// Decode-to-execute inputs, branch redirect/stall outputs and the
// execute-to-memory pipeline register outputs, bundled as one bus.
interface execute_cycle_if;
    import execute_cycle_pkg::*;

    logic              RegWriteE;
    logic              MemWriteE;
    logic              ResultSrcE;
    logic              BranchE;
    logic              ALUSrcE;
    logic              MulE;
    logic [2:0]        ALUControlE;
    logic [DATA_W-1:0] RD1_E;
    logic [DATA_W-1:0] RD2_E;
    logic [DATA_W-1:0] Imm_Ext_E;
    logic [DATA_W-1:0] PCE;
    logic [DATA_W-1:0] PCPlus4E;
    logic [REG_W-1:0]  RD_E;
    logic [1:0]        ForwardA_E;
    logic [1:0]        ForwardB_E;
    logic [DATA_W-1:0] ResultW;

    logic              PCSrcE;
    logic [DATA_W-1:0] PCTargetE;
    logic              StallE;

    logic              RegWriteM;
    logic              MemWriteM;
    logic              ResultSrcM;
    logic [REG_W-1:0]  RD_M;
    logic [DATA_W-1:0] PCPlus4M;
    logic [DATA_W-1:0] WriteDataM;
    logic [DATA_W-1:0] ALU_ResultM;

    modport master (
        output RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE, MulE,
               ALUControlE, RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RD_E,
               ForwardA_E, ForwardB_E, ResultW,
        input  PCSrcE, PCTargetE, StallE,
               RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M,
               WriteDataM, ALU_ResultM
    );

    modport slave (
        input  RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE, MulE,
               ALUControlE, RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RD_E,
               ForwardA_E, ForwardB_E, ResultW,
        output PCSrcE, PCTargetE, StallE,
               RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M,
               WriteDataM, ALU_ResultM
    );

endinterface

// File: rtl/execute_cycle_mul_iter.sv
// Iterative 32x32 shift-add multiplier returning the low 32 product bits;
// one accept cycle, MUL_STEPS busy cycles, one done cycle.
module mul_iter
    import execute_cycle_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam logic [4:0] STEP_LAST = 5'(MUL_STEPS - 1);

    mul_state_e        state_q, state_d;
    logic [4:0]        cnt_q;
    logic [DATA_W-1:0] mcand_q;
    logic [DATA_W-1:0] mplier_q;
    logic [DATA_W-1:0] prod_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= MUL_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MUL_IDLE: if (start) state_d = MUL_BUSY;
            MUL_BUSY: if (cnt_q == STEP_LAST) state_d = MUL_DONE;
            MUL_DONE: state_d = MUL_IDLE;
            default:  state_d = MUL_IDLE;
        endcase
    end

    // Unsigned shift-add; the low word matches MUL regardless of operand signs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
        end else if (state_q == MUL_IDLE && start) begin
            cnt_q    <= '0;
            mcand_q  <= a;
            mplier_q <= b;
            prod_q   <= '0;
        end else if (state_q == MUL_BUSY) begin
            cnt_q    <= cnt_q + 5'd1;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            prod_q   <= prod_q + (mplier_q[0] ? mcand_q : '0);
        end
    end

    assign busy    = (state_q == MUL_BUSY);
    assign done    = (state_q == MUL_DONE);
    assign product = prod_q;

endmodule

// File: rtl/execute_cycle.sv
// RISC-V execute stage: forwarding muxes, inline ALU, branch resolution,
// iterative MUL with stall, and the E/M pipeline register.
module execute_cycle
    import execute_cycle_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    execute_cycle_if.slave bus
);

    logic [DATA_W-1:0] src_a, fwd_b, src_b, alu_res;
    logic              zero;
    logic              mul_busy, mul_done, stall_raw;
    logic [DATA_W-1:0] mul_prod;

    logic              vld_p1;
    logic              reg_write_p1, mem_write_p1, result_src_p1;
    logic [REG_W-1:0]  rd_p1;
    logic [DATA_W-1:0] pc_plus4_p1, write_data_p1, alu_res_p1;

    function automatic logic [DATA_W-1:0] fwd_sel(
        input logic [1:0]        sel,
        input logic [DATA_W-1:0] reg_val,
        input logic [DATA_W-1:0] wb_val,
        input logic [DATA_W-1:0] mem_val
    );
        case (sel)
            FWD_WB:  fwd_sel = wb_val;
            FWD_MEM: fwd_sel = mem_val;
            default: fwd_sel = reg_val;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] alu_calc(
        input logic [2:0]        op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic signed [DATA_W-1:0] sa;
        logic signed [DATA_W-1:0] sb;
        sa = a;
        sb = b;
        case (op)
            ALU_ADD: alu_calc = a + b;
            ALU_SUB: alu_calc = a - b;
            ALU_AND: alu_calc = a & b;
            ALU_OR:  alu_calc = a | b;
            ALU_SLT: alu_calc = {{(DATA_W-1){1'b0}}, (sa < sb)};
            default: alu_calc = '0;
        endcase
    endfunction

    // Stage E: operand selection, ALU and branch resolution
    always_comb begin
        src_a   = fwd_sel(bus.ForwardA_E, bus.RD1_E, bus.ResultW, bus.ALU_ResultM);
        fwd_b   = fwd_sel(bus.ForwardB_E, bus.RD2_E, bus.ResultW, bus.ALU_ResultM);
        src_b   = bus.ALUSrcE ? bus.Imm_Ext_E : fwd_b;
        alu_res = alu_calc(bus.ALUControlE, src_a, src_b);
        zero    = (alu_res == '0);
    end

    mul_iter u_mul_iter (
        .clk     (clk),
        .rst     (rst),
        .start   (bus.MulE),
        .a       (src_a),
        .b       (fwd_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod)
    );

    // DONE is excluded so a still-high MulE cannot re-trigger the accept stall.
    assign stall_raw     = mul_busy | (bus.MulE & ~mul_busy & ~mul_done);
    assign bus.StallE    = stall_raw & rst;
    assign bus.PCTargetE = bus.PCE + bus.Imm_Ext_E;
    assign bus.PCSrcE    = bus.BranchE & zero & ~bus.StallE & ~bus.MulE;

    // Stage E -> M register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1        <= 1'b0;
            reg_write_p1  <= 1'b0;
            mem_write_p1  <= 1'b0;
            result_src_p1 <= 1'b0;
            rd_p1         <= '0;
            pc_plus4_p1   <= '0;
            write_data_p1 <= '0;
            alu_res_p1    <= '0;
        end else if (stall_raw) begin
            vld_p1        <= 1'b0;
            reg_write_p1  <= 1'b0;
            mem_write_p1  <= 1'b0;
            result_src_p1 <= 1'b0;
            rd_p1         <= '0;
            pc_plus4_p1   <= '0;
            write_data_p1 <= '0;
            alu_res_p1    <= '0;
        end else if (mul_done) begin
            vld_p1        <= 1'b1;
            reg_write_p1  <= bus.RegWriteE;
            mem_write_p1  <= 1'b0;
            result_src_p1 <= 1'b0;
            rd_p1         <= bus.RD_E;
            pc_plus4_p1   <= bus.PCPlus4E;
            write_data_p1 <= '0;
            alu_res_p1    <= mul_prod;
        end else begin
            vld_p1        <= 1'b1;
            reg_write_p1  <= bus.RegWriteE;
            mem_write_p1  <= bus.MemWriteE;
            result_src_p1 <= bus.ResultSrcE;
            rd_p1         <= bus.RD_E;
            pc_plus4_p1   <= bus.PCPlus4E;
            write_data_p1 <= fwd_b;
            alu_res_p1    <= alu_res;
        end
    end

    assign bus.RegWriteM   = reg_write_p1 & vld_p1;
    assign bus.MemWriteM   = mem_write_p1 & vld_p1;
    assign bus.ResultSrcM  = result_src_p1;
    assign bus.RD_M        = rd_p1;
    assign bus.PCPlus4M    = pc_plus4_p1;
    assign bus.WriteDataM  = write_data_p1;
    assign bus.ALU_ResultM = alu_res_p1;

endmodule

// File: tb/tb_execute_cycle.sv
// Bench for execute_cycle: directed steps plus randomized ALU traffic checked
// against an arithmetic reference model.
module tb_execute_cycle;
    import execute_cycle_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    execute_cycle_if bus ();

    execute_cycle dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd5:    return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] r,
                                            input logic [31:0] wb, input logic [31:0] mem);
        if (sel == 2'd1) return wb;
        if (sel == 2'd2) return mem;
        return r;
    endfunction

    task automatic set_e(input logic rw, input logic mw, input logic rs, input logic br,
                         input logic als, input logic mul, input logic [2:0] ctl,
                         input logic [31:0] rd1, input logic [31:0] rd2,
                         input logic [31:0] imm, input logic [31:0] pc,
                         input logic [31:0] pc4, input logic [4:0] rd,
                         input logic [1:0] fa, input logic [1:0] fb,
                         input logic [31:0] resw);
        bus.RegWriteE   = rw;
        bus.MemWriteE   = mw;
        bus.ResultSrcE  = rs;
        bus.BranchE     = br;
        bus.ALUSrcE     = als;
        bus.MulE        = mul;
        bus.ALUControlE = ctl;
        bus.RD1_E       = rd1;
        bus.RD2_E       = rd2;
        bus.Imm_Ext_E   = imm;
        bus.PCE         = pc;
        bus.PCPlus4E    = pc4;
        bus.RD_E        = rd;
        bus.ForwardA_E  = fa;
        bus.ForwardB_E  = fb;
        bus.ResultW     = resw;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] m_alu;
        logic [2:0]  op;
        logic [1:0]  fa, fb;
        logic [31:0] rd1, rd2, imm, resw, pc, pc4, a, b, sb, r;
        logic        als, br, rw, mw, rs;
        logic [4:0]  rd;

        set_e(0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 5'd0, 2'd0, 2'd0, 0);
        #12;
        chk("reset_RegWriteM", {31'd0, bus.RegWriteM}, 32'd0);
        chk("reset_ALU_ResultM", bus.ALU_ResultM, 32'd0);
        chk("reset_RD_M", {27'd0, bus.RD_M}, 32'd0);
        chk("reset_WriteDataM", bus.WriteDataM, 32'd0);
        chk("reset_PCPlus4M", bus.PCPlus4M, 32'd0);
        chk("reset_StallE", {31'd0, bus.StallE}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // add 5 + imm 7
        set_e(1, 0, 0, 0, 1, 0, 3'd0, 32'd5, 32'd0, 32'd7, 0, 32'h10, 5'd3, 2'd0, 2'd0, 0);
        tick();
        chk("add_ALU_ResultM", bus.ALU_ResultM, 32'd12);
        chk("add_RegWriteM", {31'd0, bus.RegWriteM}, 32'd1);
        chk("add_RD_M", {27'd0, bus.RD_M}, 32'd3);

        // sub 9 - 9 with branch
        set_e(0, 0, 0, 1, 0, 0, 3'd1, 32'd9, 32'd9, 32'h20, 32'h100, 0, 5'd0, 2'd0, 2'd0, 0);
        @(negedge clk);
        chk("beq_PCSrcE", {31'd0, bus.PCSrcE}, 32'd1);
        chk("beq_PCTargetE", bus.PCTargetE, 32'h120);
        tick();
        chk("beq_ALU_ResultM", bus.ALU_ResultM, 32'd0);
        chk("beq_RegWriteM", {31'd0, bus.RegWriteM}, 32'd0);

        // forwarding: produce 0x30 in M, then or(ALU_ResultM, ResultW)
        set_e(1, 0, 0, 0, 1, 0, 3'd0, 32'h30, 0, 32'd0, 0, 0, 5'd4, 2'd0, 2'd0, 0);
        tick();
        chk("fwd_setup", bus.ALU_ResultM, 32'h30);
        set_e(1, 0, 0, 0, 0, 0, 3'd3, 32'hdead, 32'hbeef, 0, 0, 0, 5'd5, 2'd2, 2'd1, 32'h4);
        tick();
        chk("fwd_or_result", bus.ALU_ResultM, 32'h34);
        chk("fwd_write_data", bus.WriteDataM, 32'h4);

        set_e(1, 0, 0, 0, 0, 0, 3'd5, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 5'd6, 2'd0, 2'd0, 0);
        tick();
        chk("slt_neg", bus.ALU_ResultM, 32'd1);
        m_alu = 32'd1;

        for (int i = 0; i < 24; i++) begin
            op   = 3'($urandom_range(0, 7));
            fa   = 2'($urandom_range(0, 3));
            fb   = 2'($urandom_range(0, 3));
            rd1  = $urandom;
            rd2  = (i % 4 == 0) ? rd1 : $urandom;
            imm  = $urandom;
            resw = $urandom;
            pc   = $urandom;
            pc4  = $urandom;
            als  = 1'($urandom_range(0, 1));
            br   = 1'($urandom_range(0, 1));
            rw   = 1'($urandom_range(0, 1));
            mw   = 1'($urandom_range(0, 1));
            rs   = 1'($urandom_range(0, 1));
            rd   = 5'($urandom_range(0, 31));
            if (i % 4 == 0) begin
                op = 3'd1; als = 1'b0; br = 1'b1;
                fa = 2'd0; fb = 2'd0;
            end
            set_e(rw, mw, rs, br, als, 0, op, rd1, rd2, imm, pc, pc4, rd, fa, fb, resw);
            a  = ref_fwd(fa, rd1, resw, m_alu);
            b  = ref_fwd(fb, rd2, resw, m_alu);
            sb = als ? imm : b;
            r  = ref_alu(op, a, sb);
            @(negedge clk);
            chk("rnd_PCTargetE", bus.PCTargetE, pc + imm);
            chk("rnd_PCSrcE", {31'd0, bus.PCSrcE}, {31'd0, (br && r == 32'd0)});
            chk("rnd_StallE", {31'd0, bus.StallE}, 32'd0);
            tick();
            chk("rnd_ALU_ResultM", bus.ALU_ResultM, r);
            chk("rnd_WriteDataM", bus.WriteDataM, b);
            chk("rnd_RegWriteM", {31'd0, bus.RegWriteM}, {31'd0, rw});
            chk("rnd_MemWriteM", {31'd0, bus.MemWriteM}, {31'd0, mw});
            chk("rnd_ResultSrcM", {31'd0, bus.ResultSrcM}, {31'd0, rs});
            chk("rnd_RD_M", {27'd0, bus.RD_M}, {27'd0, rd});
            chk("rnd_PCPlus4M", bus.PCPlus4M, pc4);
            m_alu = r;
        end

        // MUL 0xFFFFFFFF x 3, MulE held through DONE
        set_e(1, 1, 0, 0, 0, 1, 3'd0, 32'hFFFF_FFFF, 32'd3, 0, 0, 32'h44, 5'd7, 2'd0, 2'd0, 0);
        for (int k = 0; k < 33; k++) begin
            @(negedge clk);
            chk("mul1_StallE", {31'd0, bus.StallE}, 32'd1);
            tick();
            chk("mul1_bubble_alu", bus.ALU_ResultM, 32'd0);
            chk("mul1_bubble_rw", {31'd0, bus.RegWriteM}, 32'd0);
            chk("mul1_bubble_mw", {31'd0, bus.MemWriteM}, 32'd0);
            chk("mul1_bubble_rd", {27'd0, bus.RD_M}, 32'd0);
        end
        @(negedge clk);
        chk("mul1_done_StallE", {31'd0, bus.StallE}, 32'd0);
        tick();
        chk("mul1_product", bus.ALU_ResultM, 32'hFFFF_FFFD);
        chk("mul1_RegWriteM", {31'd0, bus.RegWriteM}, 32'd1);
        chk("mul1_RD_M", {27'd0, bus.RD_M}, 32'd7);
        chk("mul1_PCPlus4M", bus.PCPlus4M, 32'h44);
        chk("mul1_MemWriteM", {31'd0, bus.MemWriteM}, 32'd0);
        set_e(1, 0, 0, 0, 1, 0, 3'd0, 32'd1, 0, 32'd2, 0, 0, 5'd8, 2'd0, 2'd0, 0);
        @(negedge clk);
        chk("mul1_no_restart", {31'd0, bus.StallE}, 32'd0);
        tick();
        chk("post_mul_add", bus.ALU_ResultM, 32'd3);

        // MUL 6 x 7 with operands disturbed during BUSY, branch asserted illegally
        set_e(1, 0, 0, 1, 0, 1, 3'd7, 32'h99, 32'd7, 0, 0, 32'h80, 5'd9, 2'd1, 2'd0, 32'd6);
        @(negedge clk);
        chk("mul2_PCSrcE", {31'd0, bus.PCSrcE}, 32'd0);
        chk("mul2_StallE", {31'd0, bus.StallE}, 32'd1);
        tick();
        for (int k = 0; k < 32; k++) begin
            bus.ResultW    = $urandom;
            bus.RD1_E      = $urandom;
            bus.RD2_E      = $urandom;
            bus.ForwardA_E = 2'($urandom_range(0, 3));
            tick();
        end
        @(negedge clk);
        chk("mul2_done_StallE", {31'd0, bus.StallE}, 32'd0);
        tick();
        chk("mul2_product", bus.ALU_ResultM, 32'd42);
        chk("mul2_RD_M", {27'd0, bus.RD_M}, 32'd9);

        // reset during BUSY abandons the multiply
        set_e(1, 0, 0, 0, 0, 1, 3'd0, 32'd5, 32'd9, 0, 0, 32'h90, 5'd10, 2'd0, 2'd0, 0);
        tick();
        for (int k = 0; k < 10; k++) tick();
        #1;
        bus.MulE = 1'b0;
        rst = 1'b0;
        #1;
        chk("rstbusy_StallE", {31'd0, bus.StallE}, 32'd0);
        chk("rstbusy_ALU_ResultM", bus.ALU_ResultM, 32'd0);
        chk("rstbusy_RegWriteM", {31'd0, bus.RegWriteM}, 32'd0);
        chk("rstbusy_RD_M", {27'd0, bus.RD_M}, 32'd0);
        chk("rstbusy_PCPlus4M", bus.PCPlus4M, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        set_e(0, 0, 0, 0, 0, 0, 3'd7, 32'd5, 32'd9, 0, 0, 0, 5'd0, 2'd0, 2'd0, 0);
        for (int k = 0; k < 40; k++) begin
            tick();
            chk("rstbusy_no_product", bus.ALU_ResultM, 32'd0);
            chk("rstbusy_no_write", {31'd0, bus.RegWriteM}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
